// File: rtl/proc_status_pkg.sv
// Shared encodings for the 6502 status register: flag-update selects,
// P bit positions and the reset image.
package proc_status_pkg;

  typedef enum logic [3:0] {
    FS_HOLD = 4'h0,
    FS_NZ   = 4'h1,
    FS_NZC  = 4'h2,
    FS_NZCV = 4'h3,
    FS_BIT  = 4'h4,
    FS_SEC  = 4'h5,
    FS_CLC  = 4'h6,
    FS_SEI  = 4'h7,
    FS_CLI  = 4'h8,
    FS_SED  = 4'h9,
    FS_CLD  = 4'hA,
    FS_CLV  = 4'hB,
    FS_PULL = 4'hC,
    FS_INTR = 4'hD
  } flag_sel_e;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_U = 5;
  localparam int P_B = 4;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  localparam logic [7:0] P_RESET = 8'h24;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

endpackage

// File: rtl/proc_status.sv
// 6502 processor status register (P) fed by the ALU, flag instructions, pulls and
// interrupt entry. Build option: DECIMAL_MODE_EN enables D's effect on the ALU path.
module proc_status
  import proc_status_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [3:0] flag_sel,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic [7:0] bit_mem,
  input  logic [7:0] db_in,
  input  logic       brk_push,
  output logic [7:0] p_out,
  output logic       carry_flag,
  output logic       decimal_flag,
  output logic       irq_mask
);

  flags_t flags;
  flags_t flags_nxt;
  logic   irq_mask_q;
  logic   alu_zero;
  logic   unused_db;

  assign alu_zero  = (alu_Y == 8'h00);
  // B and the constant bit are never stored, so the pulled copies are dropped.
  assign unused_db = ^db_in[P_U:P_B];

  always_comb begin
    // NOTE: defaulting to the current flags first keeps every path assigned,
    // so no latch is inferred and unlisted selects naturally hold.
    flags_nxt = flags;
    case (flag_sel)
      FS_NZ: begin
        flags_nxt.n = alu_Y[7];
        flags_nxt.z = alu_zero;
      end
      FS_NZC: begin
        flags_nxt.n = alu_Y[7];
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
      end
      FS_NZCV: begin
        flags_nxt.n = alu_Y[7];
        flags_nxt.z = alu_zero;
        flags_nxt.c = alu_carry_out;
        flags_nxt.v = alu_overflow;
      end
      FS_BIT: begin
        flags_nxt.n = bit_mem[7];
        flags_nxt.v = bit_mem[6];
        flags_nxt.z = alu_zero;
      end
      FS_SEC:  flags_nxt.c = 1'b1;
      FS_CLC:  flags_nxt.c = 1'b0;
      FS_SEI:  flags_nxt.i = 1'b1;
      FS_CLI:  flags_nxt.i = 1'b0;
      FS_SED:  flags_nxt.d = 1'b1;
      FS_CLD:  flags_nxt.d = 1'b0;
      FS_CLV:  flags_nxt.v = 1'b0;
      FS_PULL: begin
        flags_nxt.n = db_in[P_N];
        flags_nxt.v = db_in[P_V];
        flags_nxt.d = db_in[P_D];
        flags_nxt.i = db_in[P_I];
        flags_nxt.z = db_in[P_Z];
        flags_nxt.c = db_in[P_C];
      end
      FS_INTR: flags_nxt.i = 1'b1;
      default: ;
    endcase
  end

  // irq_mask samples the pre-edge I, giving polling its one-cycle delay.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let irq_mask_q read the old flags.i on the same edge.
    if (reset) begin
      flags      <= FLAGS_RESET;
      irq_mask_q <= 1'b1;
    end else if (ce) begin
      flags      <= flags_nxt;
      irq_mask_q <= flags.i;
    end
  end

  assign p_out      = {flags.n, flags.v, 1'b1, brk_push, flags.d, flags.i, flags.z, flags.c};
  assign carry_flag = flags.c;
  assign irq_mask   = irq_mask_q;

`ifdef DECIMAL_MODE_EN
  assign decimal_flag = flags.d;
`else
  // D stays architecturally visible in p_out; only its ALU effect is suppressed.
  assign decimal_flag = 1'b0;
`endif

endmodule

// File: tb/tb_proc_status.sv
// Self-checking bench for proc_status: directed scenarios plus randomized traffic
// compared against a byte-level model of the P register.
module tb_proc_status;
  import proc_status_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [3:0] flag_sel;
  logic [7:0] alu_y;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic [7:0] bit_mem;
  logic [7:0] db_in;
  logic       brk_push;
  logic [7:0] p_out;
  logic       carry_flag;
  logic       decimal_flag;
  logic       irq_mask;

  int tests = 0;
  int fails = 0;

  // Model state: P byte (bits 5/4 kept at zero) and the delayed interrupt mask.
  logic [7:0] p_m;
  logic       irq_m;

  always #5 clk = ~clk;

  proc_status dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .flag_sel     (flag_sel),
    .alu_Y        (alu_y),
    .alu_carry_out(alu_carry_out),
    .alu_overflow (alu_overflow),
    .bit_mem      (bit_mem),
    .db_in        (db_in),
    .brk_push     (brk_push),
    .p_out        (p_out),
    .carry_flag   (carry_flag),
    .decimal_flag (decimal_flag),
    .irq_mask     (irq_mask)
  );

  function automatic logic [7:0] model_next(input logic [7:0] p, input logic [3:0] sel);
    logic [7:0] r;
    r = p;
    case (sel)
      4'h1: begin r[7] = alu_y[7]; r[1] = (alu_y == 0); end
      4'h2: begin r[7] = alu_y[7]; r[1] = (alu_y == 0); r[0] = alu_carry_out; end
      4'h3: begin r[7] = alu_y[7]; r[1] = (alu_y == 0); r[0] = alu_carry_out; r[6] = alu_overflow; end
      4'h4: begin r[7] = bit_mem[7]; r[6] = bit_mem[6]; r[1] = (alu_y == 0); end
      4'h5: r = p | 8'h01;
      4'h6: r = p & ~8'h01;
      4'h7: r = p | 8'h04;
      4'h8: r = p & ~8'h04;
      4'h9: r = p | 8'h08;
      4'hA: r = p & ~8'h08;
      4'hB: r = p & ~8'h40;
      4'hC: r = db_in & 8'hCF;
      4'hD: r = p | 8'h04;
      default: r = p;
    endcase
    return r;
  endfunction

  function automatic logic expected_decimal(input logic [7:0] p);
`ifdef DECIMAL_MODE_EN
    return p[3];
`else
    return 1'b0 & p[3];
`endif
  endfunction

  // Expected {p_out, carry_flag, decimal_flag, irq_mask} from the model.
  function automatic logic [10:0] expected_vec();
    logic [7:0] po;
    po = p_m | 8'h20 | (brk_push ? 8'h10 : 8'h00);
    return {po, p_m[0], expected_decimal(p_m), irq_m};
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic step();
    if (reset) begin
      p_m   = 8'h04;
      irq_m = 1'b1;
    end else if (ce) begin
      irq_m = p_m[2];
      p_m   = model_next(p_m, flag_sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] sel, input logic [7:0] y, input logic co,
                        input logic ov, input logic [7:0] bm, input logic [7:0] db);
    flag_sel      = sel;
    alu_y         = y;
    alu_carry_out = co;
    alu_overflow  = ov;
    bit_mem       = bm;
    db_in         = db;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    brk_push = 1'b0;
    set_op(FS_HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();
    reset = 1'b0;
    tests++;
    if ({p_out, carry_flag, decimal_flag, irq_mask} !== {8'h24, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: p=%h c=%b d=%b irq=%b, expected p=24 c=0 d=0 irq=1",
               p_out, carry_flag, decimal_flag, irq_mask);
    end
  endtask

  task automatic test_alu_flags();
    set_op(FS_NZCV, 8'h80, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    tests++;
    if (p_out !== 8'hE4) begin
      fails++; $display("FAIL nzcv: p=%h expected E4", p_out);
    end
    set_op(FS_NZ, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if (p_out !== 8'h66) begin
      fails++; $display("FAIL nz_zero: p=%h expected 66", p_out);
    end
  endtask

  task automatic test_pull();
    set_op(FS_PULL, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF);
    step();
    tests++;
    if (p_out !== 8'hEF) begin
      fails++; $display("FAIL pull: p=%h expected EF", p_out);
    end
    tests++;
`ifdef DECIMAL_MODE_EN
    if (decimal_flag !== 1'b1) begin
      fails++; $display("FAIL pull_decimal: d=%b expected 1", decimal_flag);
    end
`else
    if (decimal_flag !== 1'b0) begin
      fails++; $display("FAIL pull_decimal: d=%b expected 0", decimal_flag);
    end
`endif
    brk_push = 1'b1;
    #1;
    tests++;
    if (p_out !== 8'hFF) begin
      fails++; $display("FAIL brk_push: p=%h expected FF", p_out);
    end
    brk_push = 1'b0;
  endtask

  task automatic test_irq_delay();
    set_op(FS_HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    set_op(FS_CLI, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if ({p_out[2], irq_mask} !== 2'b01) begin
      fails++; $display("FAIL cli_edge_n: I=%b irq=%b expected I=0 irq=1", p_out[2], irq_mask);
    end
    set_op(FS_HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if (irq_mask !== 1'b0) begin
      fails++; $display("FAIL cli_edge_n1: irq=%b expected 0", irq_mask);
    end
    set_op(FS_INTR, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if ({p_out[2], irq_mask} !== 2'b10) begin
      fails++; $display("FAIL intr_edge_n: I=%b irq=%b expected I=1 irq=0", p_out[2], irq_mask);
    end
    set_op(FS_HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if (irq_mask !== 1'b1) begin
      fails++; $display("FAIL intr_edge_n1: irq=%b expected 1", irq_mask);
    end
  endtask

  task automatic test_bit_and_carry();
    logic c_before;
    c_before = carry_flag;
    set_op(FS_BIT, 8'h00, ~c_before, 1'b0, 8'hC0, 8'h00);
    step();
    tests++;
    if ({p_out[7], p_out[6], p_out[1], carry_flag} !== {1'b1, 1'b1, 1'b1, c_before}) begin
      fails++; $display("FAIL bit: NVZC=%b%b%b%b expected 111%b",
                        p_out[7], p_out[6], p_out[1], carry_flag, c_before);
    end
    set_op(FS_SEC, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if (carry_flag !== 1'b1) begin
      fails++; $display("FAIL sec: c=%b expected 1", carry_flag);
    end
    set_op(FS_NZC, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    tests++;
    if (carry_flag !== 1'b0) begin
      fails++; $display("FAIL nzc_carry: c=%b expected 0", carry_flag);
    end
  endtask

  task automatic test_ce_and_reset_priority();
    logic [7:0] held;
    held = p_out;
    ce = 1'b0;
    set_op(FS_SEC, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if ({p_out, irq_mask} !== {held, 1'b1}) begin
        fails++; $display("FAIL ce_hold[%0d]: p=%h irq=%b expected p=%h irq=1", k, p_out, irq_mask, held);
      end
    end
    ce = 1'b1;
    set_op(FS_SED, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    reset = 1'b1;
    set_op(FS_SEC, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    reset = 1'b0;
    tests++;
    if ({p_out, carry_flag, decimal_flag, irq_mask} !== {8'h24, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL reset_wins: p=%h c=%b d=%b irq=%b expected p=24 c=0 d=0 irq=1",
                        p_out, carry_flag, decimal_flag, irq_mask);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 39) == 0);
      ce       = ($urandom_range(0, 4) != 0);
      brk_push = $urandom_range(0, 1);
      set_op(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) alu_y = 8'h00;
      step();
      exp = expected_vec();
      tests++;
      if ({p_out, carry_flag, decimal_flag, irq_mask} !== exp) begin
        fails++;
        $display("FAIL random[%0d] sel=%h: got p=%h c=%b d=%b irq=%b, expected p=%h c=%b d=%b irq=%b",
                 k, flag_sel, p_out, carry_flag, decimal_flag, irq_mask,
                 exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    p_m   = 8'h04;
    irq_m = 1'b1;
    test_reset();
    test_alu_flags();
    test_pull();
    test_irq_delay();
    test_bit_and_carry();
    test_ce_and_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
